div_unit: RTL and testbench

Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU) sitting beside the ALU in the execute path of the rv32i core. It consumes the two operand words read from the register file, stalls the core while it iterates, and produces a one-cycle write-back request (address, data, write enable) that feeds the register file write port directly. Datapath: restoring radix-2 divider, one quotient bit per cycle, with a single-cycle bypass for divide-by-zero and signed overflow.

---
 rtl/div_unit.sv | 150 +++++++++++++++
 tb/tb_div_unit.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU).
// Restoring radix-2 datapath, one quotient bit per cycle, with a single-cycle bypass for x/0 and signed overflow.
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            nrst_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [4:0]      rd_addr_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] rd_data_o,
    output logic [4:0]      rd_addr_o,
    output logic            rd_wren_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [5:0]      CNT_LAST = 6'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   dvsr_q, dvsr_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic [4:0]        addr_pend_q, addr_pend_d;
    logic [4:0]        rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]   rd_data_q, rd_data_d;

    logic              is_signed;
    logic [XLEN:0]     shifted;
    logic [XLEN-1:0]   quo_fixed;
    logic [XLEN-1:0]   rem_fixed;

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q     <= IDLE;
            op_q        <= 2'b00;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            addr_pend_q <= '0;
            rd_addr_q   <= '0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            addr_pend_q <= addr_pend_d;
            rd_addr_q   <= rd_addr_d;
            rd_data_q   <= rd_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        addr_pend_d = addr_pend_q;
        rd_addr_d   = rd_addr_q;
        rd_data_d   = rd_data_q;
        is_signed   = ~op_i[0];
        shifted     = {rem_q, quo_q[XLEN-1]};
        quo_fixed   = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
        rem_fixed   = neg_rem_q ? (~rem_q + 1'b1) : rem_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    op_d        = op_i;
                    addr_pend_d = rd_addr_i;
                    if (rs2_data_i == '0) begin
                        rd_data_d = op_i[1] ? rs1_data_i : '1;
                        rd_addr_d = rd_addr_i;
                        state_d   = DONE;
                    end else if (is_signed && rs1_data_i == INT_MIN && rs2_data_i == '1) begin
                        rd_data_d = op_i[1] ? '0 : INT_MIN;
                        rd_addr_d = rd_addr_i;
                        state_d   = DONE;
                    end else begin
                        quo_d     = (is_signed && rs1_data_i[XLEN-1]) ? (~rs1_data_i + 1'b1) : rs1_data_i;
                        dvsr_d    = (is_signed && rs2_data_i[XLEN-1]) ? (~rs2_data_i + 1'b1) : rs2_data_i;
                        rem_d     = '0;
                        cnt_d     = '0;
                        neg_quo_d = is_signed && (rs1_data_i[XLEN-1] ^ rs2_data_i[XLEN-1]);
                        neg_rem_d = is_signed && rs1_data_i[XLEN-1];
                        state_d   = CALC;
                    end
                end
            end
            CALC: begin
                // Partial remainder stays below the divisor, so the 33-bit difference fits back in XLEN bits.
                if (shifted >= {1'b0, dvsr_q}) begin
                    rem_d = XLEN'(shifted - {1'b0, dvsr_q});
                    quo_d = {quo_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d = shifted[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                rd_data_d = op_q[1] ? rem_fixed : quo_fixed;
                rd_addr_d = addr_pend_q;
                state_d   = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o    = (state_q != IDLE);
    assign done_o    = (state_q == DONE);
    assign rd_data_o = rd_data_q;
    assign rd_addr_o = rd_addr_q;
    assign rd_wren_o = done_o && (rd_addr_q != 5'd0);

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: scoreboard of expected write-backs, checked against each done_o pulse.
module tb_div_unit;

    logic        clk_i;
    logic        nrst_i;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic [4:0]  rd_addr_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] rd_data_o;
    logic [4:0]  rd_addr_o;
    logic        rd_wren_o;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  addr;
        logic        wren;
    } exp_t;

    exp_t sb[$];

    div_unit #(.XLEN(32)) dut (
        .clk_i      (clk_i),
        .nrst_i     (nrst_i),
        .start_i    (start_i),
        .op_i       (op_i),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .rd_addr_i  (rd_addr_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .rd_data_o  (rd_data_o),
        .rd_addr_o  (rd_addr_o),
        .rd_wren_o  (rd_wren_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (done_o) done_cnt++;
    end

    // Drive one request at the current (negedge) time; it is sampled by the next posedge (cycle 0).
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp_data, input bit push);
        exp_t e;
        op_i       = op;
        rs1_data_i = a;
        rs2_data_i = b;
        rd_addr_i  = rd;
        start_i    = 1'b1;
        if (push) begin
            e.data = exp_data;
            e.addr = rd;
            e.wren = (rd != 5'd0);
            sb.push_back(e);
        end
        @(posedge clk_i);
        #1 start_i = 1'b0;
    endtask

    // Count cycles (sampled at negedge) until done_o, bounded; also counts cycles where busy_o was low.
    task automatic wait_done(output int lat, output bit seen, output int busy_bad);
        lat = 0;
        seen = 1'b0;
        busy_bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            lat++;
            if (!busy_o) busy_bad++;
            if (done_o) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        nrst_i = 1'b0;
        start_i = 1'b0;
        op_i = 2'b00;
        rs1_data_i = '0;
        rs2_data_i = '0;
        rd_addr_i = '0;
        repeat (2) @(negedge clk_i);
        checks++;
        if ({busy_o, done_o, rd_wren_o} !== 3'b000) begin
            failures++;
            $display("FAIL reset_ctrl busy/done/wren=%b required 000", {busy_o, done_o, rd_wren_o});
        end
        checks++;
        if (rd_data_o !== 32'd0 || rd_addr_o !== 5'd0) begin
            failures++;
            $display("FAIL reset_data data=%h addr=%0d required 0/0", rd_data_o, rd_addr_o);
        end
        nrst_i = 1'b1;
        @(negedge clk_i);
        $display("reset: released");
    endtask

    task automatic test_basic();
        int lat, bb;
        bit seen;
        exp_t e;
        logic [1:0]  ops [2] = '{2'b01, 2'b11};
        logic [31:0] res [2] = '{32'd14, 32'd2};
        for (int k = 0; k < 2; k++) begin
            issue(ops[k], 32'd100, 32'd7, 5'd5, res[k], 1'b1);
            wait_done(lat, seen, bb);
            checks++;
            if (!seen || sb.size() == 0) begin
                failures++;
                $display("FAIL basic_timeout op=%b no done_o within bound", ops[k]);
                continue;
            end
            e = sb.pop_front();
            $display("basic: op=%b 100/7 rd=5 -> data=%h addr=%0d wren=%b lat=%0d", ops[k], rd_data_o, rd_addr_o, rd_wren_o, lat);
            if (rd_data_o !== e.data) begin
                failures++;
                $display("FAIL basic_data op=%b got %h required %h", ops[k], rd_data_o, e.data);
            end
            checks++;
            if (lat != 34 || bb != 0) begin
                failures++;
                $display("FAIL basic_latency op=%b lat=%0d busy_low=%0d required 34/0", ops[k], lat, bb);
            end
            checks++;
            if (rd_addr_o !== e.addr || rd_wren_o !== e.wren) begin
                failures++;
                $display("FAIL basic_wb addr=%0d wren=%b required %0d/%b", rd_addr_o, rd_wren_o, e.addr, e.wren);
            end
            @(negedge clk_i);
            checks++;
            if ({done_o, rd_wren_o, busy_o} !== 3'b000 || rd_data_o !== e.data) begin
                failures++;
                $display("FAIL basic_after done/wren/busy=%b data=%h required 000/%h", {done_o, rd_wren_o, busy_o}, rd_data_o, e.data);
            end
        end
    endtask

    task automatic test_signs();
        int lat, bb;
        bit seen;
        exp_t e;
        logic [1:0]  ops [5] = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b01};
        logic [31:0] as  [5] = '{-32'sd100, -32'sd100, 32'd100, 32'd100, 32'hFFFF_FFFF};
        logic [31:0] bs  [5] = '{32'd7, 32'd7, -32'sd7, -32'sd7, 32'd2};
        logic [31:0] rs  [5] = '{32'hFFFF_FFF2, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 32'd2, 32'h7FFF_FFFF};
        for (int k = 0; k < 5; k++) begin
            issue(ops[k], as[k], bs[k], 5'(k + 10), rs[k], 1'b1);
            wait_done(lat, seen, bb);
            checks++;
            if (!seen || sb.size() == 0) begin
                failures++;
                $display("FAIL signs_timeout case=%0d no done_o within bound", k);
                continue;
            end
            e = sb.pop_front();
            $display("signs: op=%b %h/%h -> data=%h lat=%0d", ops[k], as[k], bs[k], rd_data_o, lat);
            if (rd_data_o !== e.data || rd_addr_o !== e.addr || lat != 34) begin
                failures++;
                $display("FAIL signs_case%0d data=%h addr=%0d lat=%0d required %h/%0d/34", k, rd_data_o, rd_addr_o, lat, e.data, e.addr);
            end
            @(negedge clk_i);
        end
    endtask

    task automatic test_bypass();
        int lat, bb;
        bit seen;
        exp_t e;
        logic [1:0]  ops [4] = '{2'b00, 2'b11, 2'b00, 2'b10};
        logic [31:0] as  [4] = '{32'd42, 32'd42, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] rs  [4] = '{32'hFFFF_FFFF, 32'd42, 32'h8000_0000, 32'd0};
        for (int k = 0; k < 4; k++) begin
            issue(ops[k], as[k], bs[k], 5'(k + 20), rs[k], 1'b1);
            wait_done(lat, seen, bb);
            checks++;
            if (!seen || sb.size() == 0) begin
                failures++;
                $display("FAIL bypass_timeout case=%0d no done_o within bound", k);
                continue;
            end
            e = sb.pop_front();
            $display("bypass: op=%b %h/%h -> data=%h lat=%0d", ops[k], as[k], bs[k], rd_data_o, lat);
            if (rd_data_o !== e.data || rd_wren_o !== e.wren || lat != 1 || bb != 0) begin
                failures++;
                $display("FAIL bypass_case%0d data=%h wren=%b lat=%0d required %h/%b/1", k, rd_data_o, rd_wren_o, lat, e.data, e.wren);
            end
            @(negedge clk_i);
            checks++;
            if (busy_o !== 1'b0 || done_o !== 1'b0) begin
                failures++;
                $display("FAIL bypass_idle case=%0d busy=%b done=%b required 0/0", k, busy_o, done_o);
            end
        end
    endtask

    task automatic test_held_start();
        int lat, base, bb;
        bit seen;
        exp_t e;
        // start_i stays high with scrambled operands through CALC and DONE.
        base = done_cnt;
        op_i = 2'b01;
        rs1_data_i = 32'd1000;
        rs2_data_i = 32'd9;
        rd_addr_i = 5'd7;
        start_i = 1'b1;
        e.data = 32'd111;
        e.addr = 5'd7;
        e.wren = 1'b1;
        sb.push_back(e);
        @(posedge clk_i);
        lat = 0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            #1;
            rs1_data_i = $urandom;
            rs2_data_i = $urandom;
            op_i = 2'($urandom_range(0, 3));
            rd_addr_i = 5'($urandom_range(0, 31));
            @(negedge clk_i);
            lat++;
            if (done_o) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen || sb.size() == 0) begin
            failures++;
            $display("FAIL held_timeout no done_o within bound");
        end else begin
            e = sb.pop_front();
            $display("held: DIVU 1000/9 rd=7 -> data=%h addr=%0d lat=%0d", rd_data_o, rd_addr_o, lat);
            if (rd_data_o !== e.data || rd_addr_o !== e.addr || lat != 34) begin
                failures++;
                $display("FAIL held_result data=%h addr=%0d lat=%0d required %h/%0d/34", rd_data_o, rd_addr_o, lat, e.data, e.addr);
            end
        end
        @(negedge clk_i);
        start_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL held_done_start busy=%b required 0", busy_o);
        end
        repeat (40) @(negedge clk_i);
        checks++;
        if (done_cnt - base != 1) begin
            failures++;
            $display("FAIL held_single done pulses=%0d required 1", done_cnt - base);
        end
        issue(2'b01, 32'd9, 32'd3, 5'd0, 32'd3, 1'b1);
        wait_done(lat, seen, bb);
        checks++;
        if (!seen || sb.size() == 0) begin
            failures++;
            $display("FAIL rd0_timeout no done_o within bound");
        end else begin
            e = sb.pop_front();
            $display("rd0: DIVU 9/3 rd=0 -> data=%h done=%b wren=%b", rd_data_o, done_o, rd_wren_o);
            if (rd_wren_o !== 1'b0 || done_o !== 1'b1 || rd_data_o !== e.data) begin
                failures++;
                $display("FAIL rd0_wren wren=%b done=%b data=%h required 0/1/%h", rd_wren_o, done_o, rd_data_o, e.data);
            end
        end
        @(negedge clk_i);
    endtask

    task automatic test_reset_mid();
        int lat, base, bb;
        bit seen;
        exp_t e;
        issue(2'b01, 32'd500, 32'd4, 5'd9, 32'd0, 1'b0);
        repeat (10) @(negedge clk_i);
        base = done_cnt;
        nrst_i = 1'b0;
        #1;
        checks++;
        if ({busy_o, done_o, rd_wren_o} !== 3'b000 || rd_data_o !== 32'd0 || rd_addr_o !== 5'd0) begin
            failures++;
            $display("FAIL midreset_outputs busy/done/wren=%b data=%h addr=%0d required 000/0/0", {busy_o, done_o, rd_wren_o}, rd_data_o, rd_addr_o);
        end
        @(negedge clk_i);
        nrst_i = 1'b1;
        repeat (40) @(negedge clk_i);
        $display("midreset: done pulses after reset=%0d", done_cnt - base);
        checks++;
        if (done_cnt - base != 0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL midreset_discard done pulses=%0d busy=%b required 0/0", done_cnt - base, busy_o);
        end
        issue(2'b01, 32'd9, 32'd3, 5'd3, 32'd3, 1'b1);
        wait_done(lat, seen, bb);
        checks++;
        if (!seen || sb.size() == 0) begin
            failures++;
            $display("FAIL midreset_fresh_timeout no done_o within bound");
        end else begin
            e = sb.pop_front();
            $display("midreset: fresh DIVU 9/3 -> data=%h lat=%0d", rd_data_o, lat);
            if (rd_data_o !== e.data || lat != 34 || rd_wren_o !== e.wren) begin
                failures++;
                $display("FAIL midreset_fresh data=%h lat=%0d wren=%b required %h/34/%b", rd_data_o, lat, rd_wren_o, e.data, e.wren);
            end
        end
        @(negedge clk_i);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_bypass();
        test_held_start();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
